piso: RTL and testbench

PISO -- requirements
Module: piso

---
 rtl/piso.sv | 167 ++++++++++++++++
 tb/tb_piso.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso.sv
// -----------------------------------------------------------------------------
// piso -- parallel-in / serial-out shift register with a small control FSM.
//
// A word on DIN is captured when LOAD is high while the block is idle (READY).
// The word is then shifted out on DOUT, one bit per clock, LSB or MSB first
// depending on LSB_FIRST. SVALID qualifies every frame bit. Once the frame is
// complete the block returns to idle and pulses DONE for one cycle. A new load
// can be accepted in that DONE cycle.
//
// Optional feature (compile-time macro PISO_PARITY_EN):
//   When defined, an even-parity bit (XOR of the captured word) follows the
//   data bits as one extra SVALID bit-time before DONE.
//
// Parameters:
//   WIDTH     - data bits per frame (>= 2)
//   LSB_FIRST - 1: DIN[0] goes out first, 0: DIN[WIDTH-1] goes out first
//
// Ports:
//   CLK    in   clock, rising edge active
//   RST    in   asynchronous active-high reset
//   DIN    in   parallel word, sampled only when a load is accepted
//   LOAD   in   load request
//   READY  out  high while idle (a load will be accepted)
//   DOUT   out  registered serial data, 0 when not shifting
//   SVALID out  high while DOUT carries a frame bit
//   DONE   out  one-cycle pulse after the last frame bit
// -----------------------------------------------------------------------------
module piso #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             DOUT,
  output logic             SVALID,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic             dout_q;
  logic             svalid_q;
  logic             done_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  // Shift-register next values. The register always holds the bits that have
  // not yet been presented, aligned so the next one sits at the output end.
  logic [WIDTH-1:0] sreg_d;
  logic             next_bit_d;
  logic [WIDTH-1:0] load_sreg_d;
  logic             load_bit_d;

  always_comb begin
    sreg_d      = '0;
    next_bit_d  = 1'b0;
    load_sreg_d = '0;
    load_bit_d  = 1'b0;
    if (LSB_FIRST != 0) begin
      sreg_d      = sreg_q >> 1;
      next_bit_d  = sreg_q[0];
      load_sreg_d = DIN >> 1;
      load_bit_d  = DIN[0];
    end else begin
      sreg_d      = sreg_q << 1;
      next_bit_d  = sreg_q[WIDTH-1];
      load_sreg_d = DIN << 1;
      load_bit_d  = DIN[WIDTH-1];
    end
  end

  // Control FSM with registered outputs. The first data bit is put on DOUT by
  // the accepting edge itself, so cnt_q is the index of the bit currently on
  // DOUT and the frame ends when the last index has been held for a cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      dout_q   <= 1'b0;
      svalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q   <= 1'b0;
          dout_q   <= 1'b0;
          svalid_q <= 1'b0;
          if (LOAD) begin
            state_q  <= SHIFT;
            cnt_q    <= '0;
            sreg_q   <= load_sreg_d;
            dout_q   <= load_bit_d;
            svalid_q <= 1'b1;
`ifdef PISO_PARITY_EN
            parity_q <= ^DIN;
`endif
          end
        end

        SHIFT: begin
          if (cnt_q == LAST_IDX) begin
            sreg_q <= '0;
`ifdef PISO_PARITY_EN
            state_q  <= PARITY;
            cnt_q    <= cnt_q + CNT_W'(1);
            dout_q   <= parity_q;
            svalid_q <= 1'b1;
`else
            state_q  <= IDLE;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            svalid_q <= 1'b0;
            done_q   <= 1'b1;
`endif
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            sreg_q <= sreg_d;
            dout_q <= next_bit_d;
          end
        end

`ifdef PISO_PARITY_EN
        PARITY: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          dout_q   <= 1'b0;
          svalid_q <= 1'b0;
          done_q   <= 1'b1;
        end
`endif

        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          sreg_q   <= '0;
          dout_q   <= 1'b0;
          svalid_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign READY  = (state_q == IDLE);
  assign DOUT   = dout_q;
  assign SVALID = svalid_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_piso.sv
// -----------------------------------------------------------------------------
// tb_piso -- self-checking bench for piso (WIDTH=4).
// Two instances share the clock and reset: dutA shifts LSB first, dutB shifts
// MSB first. Every cycle both are compared against a frame-level reference
// model; table vectors and hand sequences add independent expectations.
// -----------------------------------------------------------------------------
module tb_piso;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         loadA, loadB;
  logic [W-1:0] dinA, dinB;
  logic         readyA, doutA, svalidA, doneA;
  logic         readyB, doutB, svalidB, doneB;

  always #10 CLK = ~CLK;

  piso #(.WIDTH(W), .LSB_FIRST(1)) dutA (
    .CLK(CLK), .RST(RST), .DIN(dinA), .LOAD(loadA),
    .READY(readyA), .DOUT(doutA), .SVALID(svalidA), .DONE(doneA)
  );

  piso #(.WIDTH(W), .LSB_FIRST(0)) dutB (
    .CLK(CLK), .RST(RST), .DIN(dinB), .LOAD(loadB),
    .READY(readyB), .DOUT(doutB), .SVALID(svalidB), .DONE(doneB)
  );

  int total = 0;
  int bad   = 0;

  // Frame-level reference model: index 0 models dutA, index 1 models dutB.
  bit           mBusy [2];
  int           mIdx  [2];
  logic [W-1:0] mWord [2];
  logic         mDout [2];
  logic         mSval [2];
  logic         mDone [2];

  typedef struct {
    logic         load;
    logic [W-1:0] din;
    logic         eDout;
    logic         eSvalid;
    logic         eDone;
    logic         eReady;
  } vec_t;

  vec_t vecs[$];
  logic expSeqB [W] = '{1'b1, 1'b0, 1'b1, 1'b1};

  // Bit number idx of a frame carrying word w; idx == W is the parity bit.
  function automatic logic bitAt(int d, logic [W-1:0] w, int idx);
    if (idx == W) return ^w;
    if (d == 0) return w[idx];
    return w[W-1-idx];
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mBusy[d] = 1'b0; mIdx[d] = 0; mWord[d] = '0;
      mDout[d] = 1'b0; mSval[d] = 1'b0; mDone[d] = 1'b0;
    end
  endtask

  task automatic modelEdge(int d, logic ld, logic [W-1:0] din);
    if (mBusy[d]) begin
      if (mIdx[d] + 1 < FRAME_LEN) begin
        mIdx[d]  = mIdx[d] + 1;
        mDout[d] = bitAt(d, mWord[d], mIdx[d]);
        mSval[d] = 1'b1; mDone[d] = 1'b0;
      end else begin
        mBusy[d] = 1'b0;
        mDout[d] = 1'b0; mSval[d] = 1'b0; mDone[d] = 1'b1;
      end
    end else if (ld) begin
      mBusy[d] = 1'b1; mIdx[d] = 0; mWord[d] = din;
      mDout[d] = bitAt(d, din, 0);
      mSval[d] = 1'b1; mDone[d] = 1'b0;
    end else begin
      mDout[d] = 1'b0; mSval[d] = 1'b0; mDone[d] = 1'b0;
    end
  endtask

  task automatic checkOutput(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic checkModels();
    checkOutput("A dout",   doutA,   mDout[0]);
    checkOutput("A svalid", svalidA, mSval[0]);
    checkOutput("A done",   doneA,   mDone[0]);
    checkOutput("A ready",  readyA,  !mBusy[0]);
    checkOutput("B dout",   doutB,   mDout[1]);
    checkOutput("B svalid", svalidB, mSval[1]);
    checkOutput("B done",   doneB,   mDone[1]);
    checkOutput("B ready",  readyB,  !mBusy[1]);
    checkOutput("A done&svalid", doneA & svalidA, 1'b0);
    checkOutput("B done&svalid", doneB & svalidB, 1'b0);
  endtask

  // Drive inputs, take one rising edge, advance the model and compare.
  task automatic applyStimulus(logic ldA, logic [W-1:0] dA,
                               logic ldB, logic [W-1:0] dB);
    loadA = ldA; dinA = dA; loadB = ldB; dinB = dB;
    @(posedge CLK);
    modelEdge(0, ldA, dA);
    modelEdge(1, ldB, dB);
    #1;
    checkModels();
  endtask

  task automatic checkIdleA(string name);
    checkOutput({name, " dout"},   doutA,   1'b0);
    checkOutput({name, " svalid"}, svalidA, 1'b0);
    checkOutput({name, " done"},   doneA,   1'b0);
    checkOutput({name, " ready"},  readyA,  1'b1);
  endtask

  function automatic void addVec(logic ld, logic [W-1:0] d,
                                 logic eo, logic es, logic ed, logic er);
    vec_t v;
    v.load = ld; v.din = d; v.eDout = eo; v.eSvalid = es; v.eDone = ed; v.eReady = er;
    vecs.push_back(v);
  endfunction

  initial begin
    RST = 1'b1; loadA = 1'b0; loadB = 1'b0; dinA = '0; dinB = '0;
    modelReset();

    // Reset state, checked without relying on any clock edge.
    #25;
    checkIdleA("reset A");
    checkOutput("reset B dout",  doutB,  1'b0);
    checkOutput("reset B ready", readyB, 1'b1);
    @(posedge CLK); #1;
    RST = 1'b0;

`ifndef PISO_PARITY_EN
    // 1001 LSB first
    addVec(1, 4'b1001, 1, 1, 0, 0);
    addVec(0, 4'b0000, 0, 1, 0, 0);
    addVec(0, 4'b0000, 0, 1, 0, 0);
    addVec(0, 4'b0000, 1, 1, 0, 0);
    addVec(0, 4'b0000, 0, 0, 1, 1);
    addVec(0, 4'b0000, 0, 0, 0, 1);
    // Load of 0110 while busy must be ignored
    addVec(1, 4'b1001, 1, 1, 0, 0);
    addVec(1, 4'b0110, 0, 1, 0, 0);
    addVec(0, 4'b0110, 0, 1, 0, 0);
    addVec(0, 4'b0000, 1, 1, 0, 0);
    addVec(0, 4'b0000, 0, 0, 1, 1);
    addVec(0, 4'b0000, 0, 0, 0, 1);
    // LOAD held high: 1001 then 1011, one DONE cycle between frames
    addVec(1, 4'b1001, 1, 1, 0, 0);
    addVec(1, 4'b1011, 0, 1, 0, 0);
    addVec(1, 4'b1011, 0, 1, 0, 0);
    addVec(1, 4'b1011, 1, 1, 0, 0);
    addVec(1, 4'b1011, 0, 0, 1, 1);
    addVec(1, 4'b1011, 1, 1, 0, 0);
    addVec(0, 4'b0000, 1, 1, 0, 0);
    addVec(0, 4'b0000, 0, 1, 0, 0);
    addVec(0, 4'b0000, 1, 1, 0, 0);
    addVec(0, 4'b0000, 0, 0, 1, 1);
    addVec(0, 4'b0000, 0, 0, 0, 1);
`else
    // 1011 LSB first with even parity bit 1
    addVec(1, 4'b1011, 1, 1, 0, 0);
    addVec(0, 4'b0000, 1, 1, 0, 0);
    addVec(0, 4'b0000, 0, 1, 0, 0);
    addVec(0, 4'b0000, 1, 1, 0, 0);
    addVec(0, 4'b0000, 1, 1, 0, 0);
    addVec(0, 4'b0000, 0, 0, 1, 1);
    addVec(0, 4'b0000, 0, 0, 0, 1);
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].load, vecs[i].din, 1'b0, '0);
      checkOutput($sformatf("vec%0d dout", i),   doutA,   vecs[i].eDout);
      checkOutput($sformatf("vec%0d svalid", i), svalidA, vecs[i].eSvalid);
      checkOutput($sformatf("vec%0d done", i),   doneA,   vecs[i].eDone);
      checkOutput($sformatf("vec%0d ready", i),  readyA,  vecs[i].eReady);
    end

    // MSB-first frame of 1011 on dutB
    applyStimulus(1'b0, '0, 1'b1, 4'b1011);
    checkOutput("B seq0", doutB, expSeqB[0]);
    for (int i = 1; i < W; i++) begin
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput($sformatf("B seq%0d", i), doutB, expSeqB[i]);
    end
`ifdef PISO_PARITY_EN
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("B parity", doutB, 1'b1);
`endif
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("B end done", doneB,  1'b1);
    checkOutput("B end dout", doutB,  1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("B after done", doneB, 1'b0);
    checkOutput("B after dout", doutB, 1'b0);

    // Asynchronous reset in the middle of a frame
    applyStimulus(1'b1, 4'b1111, 1'b1, 4'b1111);
    applyStimulus(1'b0, '0, 1'b0, '0);
    #8 RST = 1'b1;
    #1;
    checkIdleA("async rst");
    checkOutput("async rst B svalid", svalidB, 1'b0);
    modelReset();
    @(posedge CLK); #1;
    checkIdleA("held rst");
    RST = 1'b0;
    applyStimulus(1'b1, 4'b0001, 1'b0, '0);
    checkOutput("post rst bit0", doutA, 1'b1);
    for (int i = 1; i < W; i++) begin
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput($sformatf("post rst bit%0d", i), doutA, 1'b0);
      checkOutput($sformatf("post rst sv%0d", i), svalidA, 1'b1);
    end
    for (int i = W; i < FRAME_LEN + 2; i++) applyStimulus(1'b0, '0, 1'b0, '0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 2) == 0), W'($urandom),
                    ($urandom_range(0, 2) == 0), W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
